// File: rtl/seg7_scan_decoder.sv
// Recovers hex nibbles from a multiplexed 7-segment bus and emits one frame per full digit scan.
// Optional: define SEG7_SCAN_ERRCNT_EN to add a saturating err_count output.
module seg7_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     seg_dig,
    output logic [4*DIGITS-1:0]   frame_hex,
    output logic [DIGITS-1:0]     frame_blank,
    output logic [DIGITS-1:0]     frame_err,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  overflow
`ifdef SEG7_SCAN_ERRCNT_EN
    ,
    output logic [7:0]            err_count
`endif
);

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    logic [6:0]                   seg_meta_q, seg_sync_q;
    logic [DIGITS-1:0]            dig_meta_q, dig_sync_q;
    logic [6+DIGITS:0]            prev_q;
    state_t                       state_q;
    logic [7:0]                   cnt_q;
    logic [DIGITS-1:0]            seen_q, seen_d;
    logic [DIGITS-1:0][3:0]       sh_nib_q;
    logic [DIGITS-1:0]            sh_blank_q, sh_err_q;

    logic [6:0]                   seg_v;
    logic                         change, onehot, capture, seen_full, slot_free, xfer;
    logic [DIGITS-1:0]            cap_mask;
    logic [3:0]                   dec_nib;
    logic                         dec_blank, dec_err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg_meta_q <= '0;
            seg_sync_q <= '0;
            dig_meta_q <= '0;
            dig_sync_q <= '0;
        end else begin
            seg_meta_q <= seg;
            seg_sync_q <= seg_meta_q;
            dig_meta_q <= seg_dig;
            dig_sync_q <= dig_meta_q;
        end
    end

    assign seg_v     = (ACTIVE_LOW != 0) ? ~seg_sync_q : seg_sync_q;
    assign change    = {seg_sync_q, dig_sync_q} != prev_q;
    assign onehot    = (dig_sync_q != '0) &&
                       ((dig_sync_q & (dig_sync_q - DIGITS'(1))) == '0);
    assign capture   = (state_q == SETTLE) && onehot && !change && (cnt_q == CNT_LAST);
    assign cap_mask  = capture ? dig_sync_q : '0;
    assign seen_full = &seen_q;
    assign slot_free = !frame_valid || frame_ready;
    assign xfer      = seen_full && slot_free;
    // A capture landing on the transfer cycle seeds the freshly cleared mask.
    assign seen_d    = xfer ? cap_mask : (seen_q | cap_mask);

    always_comb begin
        dec_nib   = 4'h0;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (seg_v)
            7'h3F: dec_nib = 4'h0;
            7'h06: dec_nib = 4'h1;
            7'h5B: dec_nib = 4'h2;
            7'h4F: dec_nib = 4'h3;
            7'h66: dec_nib = 4'h4;
            7'h6D: dec_nib = 4'h5;
            7'h7D: dec_nib = 4'h6;
            7'h07: dec_nib = 4'h7;
            7'h7F: dec_nib = 4'h8;
            7'h6F: dec_nib = 4'h9;
            7'h77: dec_nib = 4'hA;
            7'h7C: dec_nib = 4'hB;
            7'h39: dec_nib = 4'hC;
            7'h5E: dec_nib = 4'hD;
            7'h79: dec_nib = 4'hE;
            7'h71: dec_nib = 4'hF;
            7'h00: dec_blank = 1'b1;
            default: dec_err = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_q      <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            seen_q      <= '0;
            sh_nib_q    <= '0;
            sh_blank_q  <= '0;
            sh_err_q    <= '0;
            frame_hex   <= '0;
            frame_blank <= '0;
            frame_err   <= '0;
            frame_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            prev_q <= {seg_sync_q, dig_sync_q};

            case (state_q)
                IDLE: begin
                    if (onehot) begin
                        state_q <= SETTLE;
                        cnt_q   <= 8'd1;
                    end
                end
                SETTLE: begin
                    if (!onehot)                state_q <= IDLE;
                    else if (change)            cnt_q   <= 8'd1;
                    else if (cnt_q == CNT_LAST) state_q <= HOLD;
                    else                        cnt_q   <= cnt_q + 8'd1;
                end
                HOLD: begin
                    if (change) begin
                        if (onehot) begin
                            state_q <= SETTLE;
                            cnt_q   <= 8'd1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            for (int i = 0; i < DIGITS; i++) begin
                if (cap_mask[i]) begin
                    sh_nib_q[i]   <= dec_nib;
                    sh_blank_q[i] <= dec_blank;
                    sh_err_q[i]   <= dec_err;
                end
            end
            seen_q <= seen_d;

            if (xfer) begin
                frame_hex   <= sh_nib_q;
                frame_blank <= sh_blank_q;
                frame_err   <= sh_err_q;
                frame_valid <= 1'b1;
            end else if (frame_ready) begin
                frame_valid <= 1'b0;
            end

            if (capture && seen_full && !slot_free)
                overflow <= 1'b1;
        end
    end

`ifdef SEG7_SCAN_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            err_cnt_q <= '0;
        else if (capture && dec_err && (err_cnt_q != 8'hFF))
            err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: expected frames are queued as scans are driven and
// compared when the DUT hands a frame over.
module tb_seg7_scan_decoder;

    typedef struct packed {
        logic [15:0] hex;
        logic [3:0]  blank;
        logic [3:0]  err;
    } frame_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [6:0]  seg;
    logic [3:0]  seg_dig;
    logic [15:0] frame_hex;
    logic [3:0]  frame_blank, frame_err;
    logic        frame_valid, frame_ready, overflow;
`ifdef SEG7_SCAN_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    int     n_chk = 0;
    int     n_fail = 0;
    int     pops = 0;
    frame_t exp_q[$];
    frame_t frm;

    seg7_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(4), .ACTIVE_LOW(0)) dut (
        .clock       (clock),
        .reset       (reset),
        .seg         (seg),
        .seg_dig     (seg_dig),
        .frame_hex   (frame_hex),
        .frame_blank (frame_blank),
        .frame_err   (frame_err),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .overflow    (overflow)
`ifdef SEG7_SCAN_ERRCNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic show(input int d, input logic [6:0] p, input int n);
        seg     = p;
        seg_dig = 4'(1 << d);
        repeat (n) tick();
    endtask

    task automatic push(input logic [15:0] h, input logic [3:0] b, input logic [3:0] e);
        exp_q.push_back(frame_t'{h, b, e});
    endtask

    task automatic wait_pops(input int n);
        int b = 0;
        while (pops < n && b < 200) begin
            tick();
            b++;
        end
        chk("pop_count", pops, n);
    endtask

    // Each negedge with valid&ready precedes exactly one handshake edge.
    always @(negedge clock) begin
        if (!reset && frame_valid && frame_ready) begin
            chk("sb_nonempty", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                frm = exp_q.pop_front();
                chk("frame_hex", frame_hex, frm.hex);
                chk("frame_blank", frame_blank, frm.blank);
                chk("frame_err", frame_err, frm.err);
            end
            pops++;
        end
    end

    initial begin
        reset = 1'b1; seg = '0; seg_dig = '0; frame_ready = 1'b0;
        repeat (2) tick();
        chk("rst_valid", frame_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_hex", frame_hex, 0);
        chk("rst_blank", frame_blank, 0);
        chk("rst_err", frame_err, 0);
        reset = 1'b0;
        repeat (3) tick();

        // basic scan and capture latency
        frame_ready = 1'b1;
        push(16'h3210, 4'h0, 4'h0);
        show(0, 7'h3F, 10);
        show(1, 7'h06, 10);
        show(2, 7'h5B, 10);
        show(3, 7'h4F, 6);
        chk("lat_valid_early", frame_valid, 0);
        tick();
        chk("lat_valid_on", frame_valid, 1);
        tick();
        chk("lat_valid_drop", frame_valid, 0);
        repeat (4) tick();
        wait_pops(1);

        // toggling digit 1 never settles
        push(16'hBA16, 4'h0, 4'h0);
        for (int k = 0; k < 6; k++) show(1, (k % 2) ? 7'h7F : 7'h06, 3);
        show(0, 7'h7D, 10);
        show(2, 7'h77, 10);
        show(3, 7'h7C, 10);
        chk("toggle_no_frame", frame_valid, 0);
        show(1, 7'h06, 12);
        wait_pops(2);

        // blank and invalid patterns
        push(16'h0010, 4'b0100, 4'b1000);
        show(0, 7'h3F, 10);
        show(1, 7'h06, 10);
        show(2, 7'h00, 10);
        show(3, 7'h49, 12);
        wait_pops(3);

        // backpressure and overflow
        frame_ready = 1'b0;
        push(16'h89FE, 4'h0, 4'h0);
        push(16'h54C0, 4'h0, 4'h0);
        show(0, 7'h79, 10);
        show(1, 7'h71, 10);
        show(2, 7'h6F, 10);
        show(3, 7'h7F, 10);
        show(0, 7'h5E, 10);
        show(1, 7'h39, 10);
        show(2, 7'h66, 10);
        show(3, 7'h6D, 10);
        chk("bp_valid", frame_valid, 1);
        chk("bp_hex_held", frame_hex, 16'h89FE);
        chk("bp_no_ovf_yet", overflow, 0);
        show(0, 7'h3F, 10);
        chk("bp_overflow", overflow, 1);
        chk("bp_hex_still", frame_hex, 16'h89FE);
        frame_ready = 1'b1;
        tick();
        chk("bp_second_valid", frame_valid, 1);
        chk("bp_second_hex", frame_hex, 16'h54C0);
        wait_pops(5);
        chk("ovf_sticky", overflow, 1);

        // reset mid-settle discards the partial frame
        show(0, 7'h3F, 10);
        show(1, 7'h06, 10);
        show(2, 7'h5B, 10);
        show(3, 7'h4F, 3);
        reset = 1'b1;
        #1;
        chk("mrst_valid", frame_valid, 0);
        chk("mrst_overflow", overflow, 0);
        chk("mrst_hex", frame_hex, 0);
        chk("mrst_blank", frame_blank, 0);
        chk("mrst_err", frame_err, 0);
        tick();
        seg_dig = '0;
        tick();
        reset = 1'b0;
        repeat (5) tick();
        show(3, 7'h4F, 12);
        chk("mrst_no_frame", frame_valid, 0);

        // non-one-hot strobes never capture
        show(0, 7'h66, 10);
        show(1, 7'h06, 10);
        seg = 7'h6D;
        seg_dig = 4'b1001; repeat (20) tick();
        seg_dig = 4'b0110; repeat (20) tick();
        seg_dig = 4'b0000; repeat (20) tick();
        chk("strobe_no_frame", frame_valid, 0);
        push(16'h3514, 4'h0, 4'h0);
        show(2, 7'h6D, 12);
        wait_pops(6);

`ifdef SEG7_SCAN_ERRCNT_EN
        for (int k = 0; k < 300; k++) show(k % 2, 7'h49, 7);
        chk("err_count_sat", err_count, 8'hFF);
`endif

        repeat (5) tick();
        chk("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
